// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the oversampled JTAG TAP.
package jtag_tap_pkg;

    // IEEE 1149.1 TAP controller states
    typedef enum logic [3:0] {
        TapTestLogicReset = 4'h0,
        TapRunTestIdle    = 4'h1,
        TapSelectDrScan   = 4'h2,
        TapCaptureDr      = 4'h3,
        TapShiftDr        = 4'h4,
        TapExit1Dr        = 4'h5,
        TapPauseDr        = 4'h6,
        TapExit2Dr        = 4'h7,
        TapUpdateDr       = 4'h8,
        TapSelectIrScan   = 4'h9,
        TapCaptureIr      = 4'hA,
        TapShiftIr        = 4'hB,
        TapExit1Ir        = 4'hC,
        TapPauseIr        = 4'hD,
        TapExit2Ir        = 4'hE,
        TapUpdateIr       = 4'hF
    } tap_state_e;

    // Data register selected by the current instruction
    typedef enum logic [1:0] {
        DrIdcode,
        DrBypass,
        DrUser
    } dr_sel_e;

    // Instruction codes; any code other than IDCODE/USER selects BYPASS
    localparam logic [3:0] IR_CODE_IDCODE = 4'h1;
    localparam logic [3:0] IR_CODE_BYPASS = 4'hF;
    localparam logic [3:0] IR_CODE_USER   = 4'h8;

    // Loaded into the IR shift register at Capture-IR (zero-extended)
    localparam logic [1:0] IR_CAPTURE_PATTERN = 2'b01;

endpackage

// File: rtl/jtag_pin_sync.sv
// Synchronises the four JTAG pins into the system clock domain and derives
// single-cycle TCK rise/fall strobes from the synchronised TCK.
module jtag_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tck,
    input  logic tms,
    input  logic tdi,
    input  logic trstn,
    output logic tms_s,
    output logic tdi_s,
    output logic trstn_s,
    output logic tck_rise,
    output logic tck_fall
);

    logic [SYNC_STAGES-1:0] tck_ff;
    logic [SYNC_STAGES-1:0] tms_ff;
    logic [SYNC_STAGES-1:0] tdi_ff;
    logic [SYNC_STAGES-1:0] trstn_ff;
    logic                   tck_prev;
    logic                   tck_s;

    // Synchroniser chains (new sample enters at bit 0) plus TCK history flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_ff   <= '0;
            tms_ff   <= '1;
            tdi_ff   <= '0;
            trstn_ff <= '1;
            tck_prev <= 1'b0;
        end else begin
            tck_ff   <= {tck_ff[SYNC_STAGES-2:0], tck};
            tms_ff   <= {tms_ff[SYNC_STAGES-2:0], tms};
            tdi_ff   <= {tdi_ff[SYNC_STAGES-2:0], tdi};
            trstn_ff <= {trstn_ff[SYNC_STAGES-2:0], trstn};
            tck_prev <= tck_s;
        end
    end

    assign tck_s    = tck_ff[SYNC_STAGES-1];
    assign tms_s    = tms_ff[SYNC_STAGES-1];
    assign tdi_s    = tdi_ff[SYNC_STAGES-1];
    assign trstn_s  = trstn_ff[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_prev;
    assign tck_fall = ~tck_s & tck_prev;

endmodule

// File: rtl/jtag_tap_sampled.sv
// JTAG TAP responder clocked entirely by clk_i: TAP FSM, IR, IDCODE/BYPASS
// data registers and registered TDO. Optional USER data register is built
// when JTAG_TAP_USER_DR_EN is defined.
module jtag_tap_sampled
    import jtag_tap_pkg::*;
#(
    parameter int unsigned IR_WIDTH      = 4,
    parameter logic [31:0] IDCODE_VALUE  = 32'h1000_1C05,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned USER_DR_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     tck_i,
    input  logic                     tms_i,
    input  logic                     tdi_i,
    input  logic                     trst_ni,
    output logic                     tdo_o,
    output logic                     tdo_oe_o,
    output logic [3:0]               tap_state_o,
    output logic [IR_WIDTH-1:0]      ir_o,
    output logic [USER_DR_WIDTH-1:0] user_dr_o,
    output logic                     user_update_o,
    input  logic [USER_DR_WIDTH-1:0] user_capture_i
);

    localparam logic [IR_WIDTH-1:0] IrIdcode  = IR_WIDTH'(IR_CODE_IDCODE);
    localparam logic [IR_WIDTH-1:0] IrCapture = IR_WIDTH'(IR_CAPTURE_PATTERN);

    logic tms_s, tdi_s, trstn_s, tck_rise, tck_fall;
    logic rise, fall;

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_shift_q;
    logic [31:0]         idcode_shift_q;
    logic                bypass_q;
    logic                tdo_q, tdo_oe_q;
    dr_sel_e             dr_sel;
    logic                dr_lsb;

    jtag_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk      (clk_i),
        .rst      (rst_i),
        .tck      (tck_i),
        .tms      (tms_i),
        .tdi      (tdi_i),
        .trstn    (trst_ni),
        .tms_s    (tms_s),
        .tdi_s    (tdi_s),
        .trstn_s  (trstn_s),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

    // A synchronised TRST overrides any TCK strobe in the same cycle
    assign rise = tck_rise & trstn_s;
    assign fall = tck_fall & trstn_s;

    // TAP state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= TapTestLogicReset;
        else       state_q <= state_d;
    end

    // TAP next-state: advance on TCK rise by synchronised TMS
    always_comb begin
        state_d = state_q;
        if (!trstn_s) begin
            state_d = TapTestLogicReset;
        end else if (rise) begin
            case (state_q)
                TapTestLogicReset: state_d = tms_s ? TapTestLogicReset : TapRunTestIdle;
                TapRunTestIdle:    state_d = tms_s ? TapSelectDrScan   : TapRunTestIdle;
                TapSelectDrScan:   state_d = tms_s ? TapSelectIrScan   : TapCaptureDr;
                TapCaptureDr:      state_d = tms_s ? TapExit1Dr        : TapShiftDr;
                TapShiftDr:        state_d = tms_s ? TapExit1Dr        : TapShiftDr;
                TapExit1Dr:        state_d = tms_s ? TapUpdateDr       : TapPauseDr;
                TapPauseDr:        state_d = tms_s ? TapExit2Dr        : TapPauseDr;
                TapExit2Dr:        state_d = tms_s ? TapUpdateDr       : TapShiftDr;
                TapUpdateDr:       state_d = tms_s ? TapSelectDrScan   : TapRunTestIdle;
                TapSelectIrScan:   state_d = tms_s ? TapTestLogicReset : TapCaptureIr;
                TapCaptureIr:      state_d = tms_s ? TapExit1Ir        : TapShiftIr;
                TapShiftIr:        state_d = tms_s ? TapExit1Ir        : TapShiftIr;
                TapExit1Ir:        state_d = tms_s ? TapUpdateIr       : TapPauseIr;
                TapPauseIr:        state_d = tms_s ? TapExit2Ir        : TapPauseIr;
                TapExit2Ir:        state_d = tms_s ? TapUpdateIr       : TapShiftIr;
                TapUpdateIr:       state_d = tms_s ? TapSelectDrScan   : TapRunTestIdle;
                default:           state_d = TapTestLogicReset;
            endcase
        end
    end

    // Instruction register: capture/shift on rise, update on fall in Update-IR
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ir_q       <= IrIdcode;
            ir_shift_q <= '0;
        end else if (!trstn_s || state_q == TapTestLogicReset) begin
            ir_q <= IrIdcode;
        end else begin
            if (rise && state_q == TapCaptureIr) ir_shift_q <= IrCapture;
            if (rise && state_q == TapShiftIr)   ir_shift_q <= {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
            if (fall && state_q == TapUpdateIr)  ir_q <= ir_shift_q;
        end
    end

    // Data register selection from the current instruction
    always_comb begin
        dr_sel = DrBypass;
        if (ir_q == IrIdcode) dr_sel = DrIdcode;
`ifdef JTAG_TAP_USER_DR_EN
        else if (ir_q == IR_WIDTH'(IR_CODE_USER)) dr_sel = DrUser;
`endif
    end

    // IDCODE and BYPASS registers: capture loads only, shifting starts in Shift-DR
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idcode_shift_q <= '0;
            bypass_q       <= 1'b0;
        end else if (rise) begin
            if (dr_sel == DrIdcode && state_q == TapCaptureDr) idcode_shift_q <= IDCODE_VALUE;
            if (dr_sel == DrIdcode && state_q == TapShiftDr)
                idcode_shift_q <= {tdi_s, idcode_shift_q[31:1]};
            if (dr_sel == DrBypass && state_q == TapCaptureDr) bypass_q <= 1'b0;
            if (dr_sel == DrBypass && state_q == TapShiftDr)   bypass_q <= tdi_s;
        end
    end

`ifdef JTAG_TAP_USER_DR_EN
    logic [USER_DR_WIDTH-1:0] user_shift_q, user_dr_q;
    logic                     user_update_q;

    // USER register: capture/shift on rise, update and one-cycle pulse on fall
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            user_shift_q  <= '0;
            user_dr_q     <= '0;
            user_update_q <= 1'b0;
        end else begin
            user_update_q <= 1'b0;
            if (rise && dr_sel == DrUser && state_q == TapCaptureDr) user_shift_q <= user_capture_i;
            if (rise && dr_sel == DrUser && state_q == TapShiftDr)
                user_shift_q <= {tdi_s, user_shift_q[USER_DR_WIDTH-1:1]};
            if (fall && dr_sel == DrUser && state_q == TapUpdateDr) begin
                user_dr_q     <= user_shift_q;
                user_update_q <= 1'b1;
            end
        end
    end

    assign user_dr_o     = user_dr_q;
    assign user_update_o = user_update_q;
`else
    logic unused_user_capture;

    assign unused_user_capture = ^user_capture_i;
    assign user_dr_o           = '0;
    assign user_update_o       = 1'b0;
`endif

    // LSB of the selected data register
    always_comb begin
        dr_lsb = bypass_q;
        case (dr_sel)
            DrIdcode: dr_lsb = idcode_shift_q[0];
`ifdef JTAG_TAP_USER_DR_EN
            DrUser:   dr_lsb = user_shift_q[0];
`endif
            default:  dr_lsb = bypass_q;
        endcase
    end

    // TDO and its enable change only on TCK fall; TRST drops the enable at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else if (!trstn_s) begin
            tdo_oe_q <= 1'b0;
        end else if (fall) begin
            tdo_q    <= (state_q == TapShiftIr) ? ir_shift_q[0] : dr_lsb;
            tdo_oe_q <= (state_q == TapShiftIr) || (state_q == TapShiftDr);
        end
    end

    assign tdo_o       = tdo_q;
    assign tdo_oe_o    = tdo_oe_q;
    assign tap_state_o = state_q;
    assign ir_o        = ir_q;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Randomised bench for jtag_tap_sampled with a scan-level reference model.
module tb_jtag_tap_sampled;
    import jtag_tap_pkg::*;

    localparam int unsigned IRW = 4;
    localparam int unsigned UDW = 32;
    localparam int          H   = 6;
    localparam logic [31:0] IDC = 32'h1000_1C05;

    logic           clk = 1'b0, rst = 1'b1;
    logic           tck = 1'b0, tms = 1'b1, tdi = 1'b0, trst_n = 1'b1;
    logic           tdo, tdo_oe, user_upd;
    logic [3:0]     tap_state;
    logic [IRW-1:0] ir;
    logic [UDW-1:0] user_dr;
    logic [UDW-1:0] user_cap = '0;

    always #5 clk = ~clk;

    jtag_tap_sampled dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tck_i          (tck),
        .tms_i          (tms),
        .tdi_i          (tdi),
        .trst_ni        (trst_n),
        .tdo_o          (tdo),
        .tdo_oe_o       (tdo_oe),
        .tap_state_o    (tap_state),
        .ir_o           (ir),
        .user_dr_o      (user_dr),
        .user_update_o  (user_upd),
        .user_capture_i (user_cap)
    );

    int n_vec = 0, n_bad = 0;
    int upd_seen = 0;
    event check_ev;

    // Reference model state
    tap_state_e nxt0 [16];
    tap_state_e nxt1 [16];
    tap_state_e m_state;
    logic [3:0]  m_ir, m_irsr;
    logic [63:0] m_sr;
    int          m_len;
    logic        m_tdo, m_oe;
    logic [31:0] m_user_dr;
    int          m_upd = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_tr(tap_state_e s, tap_state_e on0, tap_state_e on1);
        nxt0[s] = on0;
        nxt1[s] = on1;
    endtask

    function automatic bit m_user_sel();
`ifdef JTAG_TAP_USER_DR_EN
        return m_ir == 4'h8;
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_reset();
        m_state = TapTestLogicReset; m_ir = 4'h1; m_irsr = '0; m_sr = '0; m_len = 1;
        m_tdo = 1'b0; m_oe = 1'b0; m_user_dr = '0;
    endtask

    task automatic m_rise(bit t, bit d);
        if (m_state == TapCaptureIr) m_irsr = 4'h1;
        if (m_state == TapShiftIr)   m_irsr = (m_irsr >> 1) | (4'(d) << 3);
        if (m_state == TapCaptureDr) begin
            if (m_ir == 4'h1)      begin m_sr = 64'(IDC);      m_len = 32;  end
            else if (m_user_sel()) begin m_sr = 64'(user_cap); m_len = UDW; end
            else                   begin m_sr = '0;            m_len = 1;   end
        end
        if (m_state == TapShiftDr) m_sr = (m_sr >> 1) | (64'(d) << (m_len - 1));
        m_state = t ? nxt1[m_state] : nxt0[m_state];
        if (m_state == TapTestLogicReset) m_ir = 4'h1;
    endtask

    task automatic m_fall();
        m_oe = (m_state == TapShiftIr) || (m_state == TapShiftDr);
        if (m_state == TapShiftIr) m_tdo = m_irsr[0];
        if (m_state == TapShiftDr) m_tdo = m_sr[0];
        if (m_state == TapUpdateIr) m_ir = m_irsr;
        if (m_state == TapUpdateDr && m_user_sel()) begin
            m_user_dr = m_sr[31:0];
            m_upd++;
        end
    endtask

    // Count clk cycles with the update pulse high
    always @(negedge clk) if (user_upd === 1'b1) upd_seen++;

    // Compare process: DUT outputs against the model at each settled point
    always @(check_ev) begin
        chk("tap_state", 64'(tap_state), 64'(m_state));
        chk("ir", 64'(ir), 64'(m_ir));
        chk("tdo_oe", 64'(tdo_oe), 64'(m_oe));
        if (m_oe) chk("tdo", 64'(tdo), 64'(m_tdo));
        chk("user_dr", 64'(user_dr), 64'(m_user_dr));
        chk("update_pulses", 64'(upd_seen), 64'(m_upd));
    end

    task automatic tck_cycle(bit t, bit d);
        tms = t; tdi = d;
        repeat (H) @(negedge clk);
        tck = 1'b1; m_rise(t, d);
        repeat (H) @(negedge clk);
        -> check_ev; #1;
        tck = 1'b0; m_fall();
        repeat (H) @(negedge clk);
        -> check_ev; #1;
    endtask

    // Sample TDO before each rise; the last bit leaves the shift state
    task automatic shift_bits(int n, logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            tck_cycle(i == n - 1, din[i]);
        end
    endtask

    task automatic goto_idle_from_any();
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    task automatic goto_shift_dr();  // from Run-Test/Idle
        tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
    endtask

    task automatic exit_to_idle();   // from Exit1-xR
        tck_cycle(1'b1, 1'b0); tck_cycle(1'b0, 1'b0);
    endtask

    task automatic load_ir(logic [3:0] code);  // from Run-Test/Idle
        logic [63:0] dummy;
        tck_cycle(1'b1, 1'b0); tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
        shift_bits(4, 64'(code), dummy);
        exit_to_idle();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] out;
        int          upd0;

        set_tr(TapTestLogicReset, TapRunTestIdle,  TapTestLogicReset);
        set_tr(TapRunTestIdle,    TapRunTestIdle,  TapSelectDrScan);
        set_tr(TapSelectDrScan,   TapCaptureDr,    TapSelectIrScan);
        set_tr(TapCaptureDr,      TapShiftDr,      TapExit1Dr);
        set_tr(TapShiftDr,        TapShiftDr,      TapExit1Dr);
        set_tr(TapExit1Dr,        TapPauseDr,      TapUpdateDr);
        set_tr(TapPauseDr,        TapPauseDr,      TapExit2Dr);
        set_tr(TapExit2Dr,        TapShiftDr,      TapUpdateDr);
        set_tr(TapUpdateDr,       TapRunTestIdle,  TapSelectDrScan);
        set_tr(TapSelectIrScan,   TapCaptureIr,    TapTestLogicReset);
        set_tr(TapCaptureIr,      TapShiftIr,      TapExit1Ir);
        set_tr(TapShiftIr,        TapShiftIr,      TapExit1Ir);
        set_tr(TapExit1Ir,        TapPauseIr,      TapUpdateIr);
        set_tr(TapPauseIr,        TapPauseIr,      TapExit2Ir);
        set_tr(TapExit2Ir,        TapShiftIr,      TapUpdateIr);
        set_tr(TapUpdateIr,       TapRunTestIdle,  TapSelectDrScan);
        m_reset();

        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", 64'(tap_state), 64'(TapTestLogicReset));
        chk("rst_ir", 64'(ir), 64'h1);
        chk("rst_tdo", 64'(tdo), 64'h0);
        chk("rst_tdo_oe", 64'(tdo_oe), 64'h0);
        -> check_ev; #1;

        // 1: TMS=1 x5 stays in Test-Logic-Reset
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
        chk("t1_state", 64'(tap_state), 64'(TapTestLogicReset));
        chk("t1_ir", 64'(ir), 64'h1);
        chk("t1_oe", 64'(tdo_oe), 64'h0);

        // 2: IDCODE read-out
        tck_cycle(1'b0, 1'b0);
        goto_shift_dr();
        shift_bits(32, 64'h0, out);
        chk("t2_idcode_stream", out, 64'h1000_1C05);
        exit_to_idle();

        // 3: BYPASS gives one-bit delay
        load_ir(4'hF);
        chk("t3_ir", 64'(ir), 64'hF);
        goto_shift_dr();
        shift_bits(4, 64'b1101, out);
        chk("t3_bypass_stream", out, 64'b1010);
        exit_to_idle();

        // 4: IR capture pattern, IR held until Update-IR
        tck_cycle(1'b1, 1'b0); tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0); tck_cycle(1'b0, 1'b0);
        shift_bits(4, 64'h0, out);
        chk("t4_ir_capture", out, 64'b0001);
        chk("t4_ir_held", 64'(ir), 64'hF);
        exit_to_idle();
        chk("t4_ir_updated", 64'(ir), 64'h0);

        // 5: TRST in the middle of Shift-DR
        load_ir(4'h1);
        goto_shift_dr();
        for (int i = 0; i < 5; i++) tck_cycle(1'b0, 1'($urandom));
        upd0   = upd_seen;
        trst_n = 1'b0;
        repeat (8 * H) @(negedge clk);
        trst_n  = 1'b1;
        m_state = TapTestLogicReset; m_ir = 4'h1; m_oe = 1'b0;
        repeat (H) @(negedge clk);
        -> check_ev; #1;
        chk("t5_state", 64'(tap_state), 64'(TapTestLogicReset));
        chk("t5_ir", 64'(ir), 64'h1);
        chk("t5_no_update", 64'(upd_seen), 64'(upd0));

        // 6: USER register (bypass behaviour when not built)
        tck_cycle(1'b0, 1'b0);
        load_ir(4'h8);
        user_cap = 32'hA5A5_0F0F;
        upd0     = upd_seen;
        goto_shift_dr();
        shift_bits(32, 64'h1234_5678, out);
        exit_to_idle();
`ifdef JTAG_TAP_USER_DR_EN
        chk("t6_user_stream", out, 64'hA5A5_0F0F);
        chk("t6_user_dr", 64'(user_dr), 64'h1234_5678);
        chk("t6_update_once", 64'(upd_seen - upd0), 64'h1);
`else
        chk("t6_bypass_stream", out, 64'h2468_ACF0);
        chk("t6_user_dr", 64'(user_dr), 64'h0);
        chk("t6_no_update", 64'(upd_seen - upd0), 64'h0);
`endif

        // Random walk with periodic instruction loads
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 0) begin
                goto_idle_from_any();
                case ($urandom_range(0, 3))
                    0:       load_ir(4'h1);
                    1:       load_ir(4'h8);
                    2:       load_ir(4'hF);
                    default: load_ir(4'($urandom));
                endcase
            end
            user_cap = $urandom;
            tck_cycle($urandom_range(0, 3) == 0, 1'($urandom));
        end

        // rst_i in the middle of a USER scan: no update
        goto_idle_from_any();
        load_ir(4'h8);
        goto_shift_dr();
        for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'($urandom));
        upd0 = upd_seen;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
        repeat (H) @(negedge clk);
        -> check_ev; #1;
        chk("rst_mid_state", 64'(tap_state), 64'(TapTestLogicReset));
        chk("rst_mid_oe", 64'(tdo_oe), 64'h0);
        chk("rst_mid_no_update", 64'(upd_seen), 64'(upd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
